// File: rtl/spi_register_controller_pkg.sv
// Shared definitions for the SPI register controller: FSM state encoding
// and the fixed command/address constants.
package spi_register_controller_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_COMMAND = 2'd1,
    STATE_WRITE   = 2'd2,
    STATE_READ    = 2'd3
  } state_t;

  localparam int CMD_READ_BIT = 7;
  localparam int STATUS_ADDR  = 0;

endpackage

// File: rtl/spi_register_file.sv
// Register file with a synchronous write port, a combinational read port and a
// flattened output; address 0 is the read-only status byte.
module spi_register_file
  import spi_register_controller_pkg::*;
#(
  parameter int REGS       = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [7:0]            status,
  output logic [7:0]            rdata,
  output logic [REGS*8-1:0]     flat
);

  // No storage exists at the status address, so writes there fall away.
  assign flat[STATUS_ADDR*8 +: 8] = status;

  for (genvar g = STATUS_ADDR + 1; g < REGS; g++) begin : g_reg
    logic [7:0] value;

    // One storage byte per writable address.
    always_ff @(posedge clk) begin
      if (reset) begin
        value <= 8'h00;
      end else if (we && (waddr == ADDR_WIDTH'(g))) begin
        value <= wdata;
      end else begin
        value <= value;
      end
    end

    assign flat[g*8 +: 8] = value;
  end

  assign rdata = flat[{raddr, 3'b000} +: 8];

endmodule

// File: rtl/spi_register_controller.sv
// Frame-level SPI controller: decodes the command byte, performs auto-increment
// register writes/reads and sequences the byte returned on MISO.
module spi_register_controller
  import spi_register_controller_pkg::*;
#(
  parameter int REGS       = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CS_i,
  input  logic                  Done_i,
  input  logic [7:0]            DataReceived_i,
  input  logic [7:0]            Status_i,
  output logic [7:0]            DataToSend_o,
  output logic [REGS*8-1:0]     Registers_o,
  output logic                  WriteStrobe_o,
  output logic [ADDR_WIDTH-1:0] WriteAddress_o,
  output logic                  Busy_o
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;
  logic                  wr_en;
  logic                  load_miso;
  logic                  armed;

  spi_register_file #(
    .REGS       (REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regs (
    .clk    (Clock),
    .reset  (Reset),
    .we     (wr_en),
    .waddr  (addr),
    .wdata  (DataReceived_i),
    .raddr  (rd_addr),
    .status (Status_i),
    .rdata  (rd_data),
    .flat   (Registers_o)
  );

  // Next-state decode; a byte completing as CS rises is still processed.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    load_miso  = 1'b0;
    rd_addr    = addr + ADDR_WIDTH'(1);
    case (state)
      STATE_IDLE: begin
        if (!CS_i && armed) begin
          next_state = STATE_COMMAND;
        end else begin
          next_state = STATE_IDLE;
        end
      end
      STATE_COMMAND: begin
        rd_addr = DataReceived_i[ADDR_WIDTH-1:0];
        if (Done_i) begin
          next_state = DataReceived_i[CMD_READ_BIT] ? STATE_READ : STATE_WRITE;
          load_miso  = DataReceived_i[CMD_READ_BIT];
        end else begin
          next_state = STATE_COMMAND;
        end
      end
      STATE_WRITE: begin
        wr_en = Done_i && (addr != ADDR_WIDTH'(STATUS_ADDR));
      end
      STATE_READ: begin
        load_miso = Done_i;
      end
      default: begin
        next_state = STATE_IDLE;
      end
    endcase
    if (CS_i) begin
      next_state = STATE_IDLE;
    end else begin
      next_state = next_state;
    end
  end

  // State, address counter, MISO byte and write-report registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= STATE_IDLE;
      addr           <= '0;
      armed          <= 1'b0;
      DataToSend_o   <= 8'h00;
      WriteStrobe_o  <= 1'b0;
      WriteAddress_o <= '0;
      Busy_o         <= 1'b0;
    end else begin
      state         <= next_state;
      Busy_o        <= (next_state != STATE_IDLE);
      WriteStrobe_o <= wr_en;
      // A reset mid-frame leaves CS low; wait for it to go high before re-arming.
      armed         <= armed | CS_i;
      if (wr_en) begin
        WriteAddress_o <= addr;
      end else begin
        WriteAddress_o <= WriteAddress_o;
      end
      if (Done_i && (state == STATE_COMMAND)) begin
        addr <= DataReceived_i[ADDR_WIDTH-1:0];
      end else if (Done_i && ((state == STATE_WRITE) || (state == STATE_READ))) begin
        addr <= addr + ADDR_WIDTH'(1);
      end else begin
        addr <= addr;
      end
      if (CS_i) begin
        DataToSend_o <= 8'h00;
      end else if (load_miso) begin
        DataToSend_o <= rd_data;
      end else begin
        DataToSend_o <= DataToSend_o;
      end
    end
  end

endmodule
